// File: rtl/regf_wb_arb_if.sv
// Writeback arbiter bus: ALU and load-return sources, decode hazard probes,
// and the register file write port.
interface regf_wb_arb_if #(
  parameter int WIDTH = 5
);
  logic             halt;
  logic             alu_we;
  logic [WIDTH-1:0] alu_addr;
  logic [31:0]      alu_data;
  logic             mem_valid;
  logic [WIDTH-1:0] mem_addr;
  logic [31:0]      mem_data;
  logic             mem_ready;
  logic [WIDTH-1:0] chk_addr_a;
  logic [WIDTH-1:0] chk_addr_b;
  logic             pend_a;
  logic             pend_b;
  logic [WIDTH-1:0] addrc;
  logic [31:0]      dc;
  logic             wec;

  modport master (
    output halt, alu_we, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           chk_addr_a, chk_addr_b,
    input  mem_ready, pend_a, pend_b, addrc, dc, wec
  );

  modport slave (
    input  halt, alu_we, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           chk_addr_a, chk_addr_b,
    output mem_ready, pend_a, pend_b, addrc, dc, wec
  );
endinterface

// File: rtl/regf_wb_arb.sv
// Register file writeback arbiter: ALU results win, load returns queue in a
// small in-order buffer and are squashed when a younger ALU write hits them.
module regf_wb_arb #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
) (
  input logic           clk,
  input logic           reset,
  regf_wb_arb_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             r_wec;
  logic [WIDTH-1:0] r_addrc;
  logic [31:0]      r_dc;

  logic             w_run;
  logic             w_alu;
  logic             w_mem_ready;
  logic             w_accept;
  logic             w_empty;
  logic             w_pop;
  logic             w_bypass;
  logic             w_push;
  logic             w_head_vld;
  logic [DEPTH-1:0] w_vld_nxt;
  logic             w_pend_a;
  logic             w_pend_b;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign w_run       = !bus.halt;
  assign w_alu       = w_run && bus.alu_we;
  assign w_mem_ready = w_run && (r_count < FULL);
  assign w_accept    = bus.mem_valid && w_mem_ready;
  assign w_empty     = (r_count == '0);
  // The head is drained (written or discarded) only in cycles the ALU leaves idle.
  assign w_pop       = w_run && !bus.alu_we && !w_empty;
  assign w_bypass    = w_run && !bus.alu_we && w_empty && w_accept;
  assign w_push      = w_accept && !w_bypass;
  assign w_head_vld  = r_vld[r_head];

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_vld_nxt = r_vld;
    if (w_alu) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_addr[i] == bus.alu_addr) w_vld_nxt[i] = 1'b0;
      end
    end
    if (w_pop) w_vld_nxt[r_head] = 1'b0;
    // A load arriving alongside an ALU write to the same register is the older one.
    if (w_push) w_vld_nxt[r_tail] = !(w_alu && (bus.mem_addr == bus.alu_addr));
  end

  always_comb begin
    w_pend_a = 1'b0;
    w_pend_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_pend_a = w_pend_a | (r_vld[i] && (r_addr[i] == bus.chk_addr_a));
      w_pend_b = w_pend_b | (r_vld[i] && (r_addr[i] == bus.chk_addr_b));
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_wec   <= 1'b0;
      r_addrc <= '0;
      r_dc    <= '0;
    end else begin
      r_vld <= w_vld_nxt;
      if (w_pop)  r_head <= f_inc(r_head);
      if (w_push) r_tail <= f_inc(r_tail);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);

      r_wec <= 1'b0;
      if (w_alu) begin
        r_wec   <= 1'b1;
        r_addrc <= bus.alu_addr;
        r_dc    <= bus.alu_data;
      end else if (w_pop) begin
        r_wec <= w_head_vld;
        if (w_head_vld) begin
          r_addrc <= r_addr[r_head];
          r_dc    <= r_data[r_head];
        end
      end else if (w_bypass) begin
        r_wec   <= 1'b1;
        r_addrc <= bus.mem_addr;
        r_dc    <= bus.mem_data;
      end
    end
  end

  // NOTE: payload storage needs no reset; the valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= bus.mem_addr;
      r_data[r_tail] <= bus.mem_data;
    end
  end

  assign bus.mem_ready = w_mem_ready;
  assign bus.pend_a    = w_pend_a;
  assign bus.pend_b    = w_pend_b;
  assign bus.wec       = r_wec;
  assign bus.addrc     = r_addrc;
  assign bus.dc        = r_dc;
endmodule

// File: tb/tb_regf_wb_arb.sv
// Self-checking bench for regf_wb_arb: directed scenarios then random traffic,
// all compared against a queue-based reference model.
module tb_regf_wb_arb;
  localparam int WIDTH = 5;
  localparam int DEPTH = 2;

  typedef struct {
    logic [WIDTH-1:0] addr;
    logic [31:0]      data;
    bit               vld;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  ent_t             mq[$];
  bit               exp_wec;
  logic [WIDTH-1:0] exp_addrc;
  logic [31:0]      exp_dc;
  bit               ad_known;

  regf_wb_arb_if #(.WIDTH(WIDTH)) bus ();

  regf_wb_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit model_pend(input logic [WIDTH-1:0] a);
    foreach (mq[i]) if (mq[i].vld && mq[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_wec   = 1'b0;
    exp_addrc = '0;
    exp_dc    = '0;
    ad_known  = 1'b1;
  endtask

  // One clock: drive inputs, check combinational outputs, advance model, check registered outputs.
  task automatic step(input bit rst, input bit hlt, input bit awe,
                      input logic [WIDTH-1:0] aa, input logic [31:0] ad,
                      input bit mv, input logic [WIDTH-1:0] ma, input logic [31:0] md,
                      input logic [WIDTH-1:0] ca, input logic [WIDTH-1:0] cb);
    bit   rdy;
    bit   acc;
    ent_t e;
    reset          = rst;
    bus.halt       = hlt;
    bus.alu_we     = awe;
    bus.alu_addr   = aa;
    bus.alu_data   = ad;
    bus.mem_valid  = mv;
    bus.mem_addr   = ma;
    bus.mem_data   = md;
    bus.chk_addr_a = ca;
    bus.chk_addr_b = cb;
    #1;
    rdy = !hlt && (mq.size() < DEPTH);
    check("mem_ready", 32'(bus.mem_ready), 32'(rdy));
    check("pend_a", 32'(bus.pend_a), 32'(model_pend(ca)));
    check("pend_b", 32'(bus.pend_b), 32'(model_pend(cb)));

    acc = mv && rdy;
    if (rst) begin
      model_reset();
    end else if (hlt) begin
      exp_wec = 1'b0;
    end else if (awe) begin
      foreach (mq[i]) if (mq[i].addr == aa) mq[i].vld = 1'b0;
      if (acc) mq.push_back('{addr: ma, data: md, vld: (ma != aa)});
      exp_wec = 1'b1; exp_addrc = aa; exp_dc = ad; ad_known = 1'b1;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (acc) mq.push_back('{addr: ma, data: md, vld: 1'b1});
      exp_wec = e.vld;
      if (e.vld) begin
        exp_addrc = e.addr; exp_dc = e.data; ad_known = 1'b1;
      end else ad_known = 1'b0;
    end else if (acc) begin
      exp_wec = 1'b1; exp_addrc = ma; exp_dc = md; ad_known = 1'b1;
    end else begin
      exp_wec = 1'b0; ad_known = 1'b0;
    end

    @(posedge clk);
    #1;
    check("wec", 32'(bus.wec), 32'(exp_wec));
    if (ad_known) begin
      check("addrc", 32'(bus.addrc), 32'(exp_addrc));
      check("dc", bus.dc, exp_dc);
    end
  endtask

  task automatic idle(input logic [WIDTH-1:0] ca, input logic [WIDTH-1:0] cb);
    step(0, 0, 0, '0, '0, 0, '0, '0, ca, cb);
  endtask

  initial begin
    reset = 1'b1;
    bus.halt = 1'b0; bus.alu_we = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
    bus.chk_addr_a = '0; bus.chk_addr_b = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_wec", 32'(bus.wec), 32'd0);
    check("rst_addrc", 32'(bus.addrc), 32'd0);
    check("rst_dc", bus.dc, 32'd0);
    idle(5'd0, 5'd1);

    // Load bypass into an empty buffer.
    step(0, 0, 0, '0, '0, 1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd0);
    check("bypass_wec", 32'(bus.wec), 32'd1);
    check("bypass_dc", bus.dc, 32'hDEADBEEF);
    idle(5'd3, 5'd0);

    // ALU burst while loads 7 and 9 queue behind it.
    step(0, 0, 1, 5'd1, 32'h101, 1, 5'd7, 32'h707, 5'd9, 5'd7);
    step(0, 0, 1, 5'd2, 32'h202, 1, 5'd9, 32'h909, 5'd9, 5'd7);
    step(0, 0, 1, 5'd4, 32'h404, 1, 5'd9, 32'h909, 5'd9, 5'd7);
    check("burst_pend9", 32'(bus.pend_a), 32'd1);
    idle(5'd9, 5'd7);
    check("drain_first", 32'(bus.addrc), 32'd7);
    idle(5'd9, 5'd7);
    check("drain_second", 32'(bus.addrc), 32'd9);
    idle(5'd9, 5'd7);

    // Younger ALU write squashes a buffered load to the same register.
    step(0, 0, 1, 5'd10, 32'hA, 1, 5'd5, 32'h11, 5'd5, 5'd0);
    step(0, 0, 1, 5'd5, 32'h22, 0, '0, '0, 5'd5, 5'd0);
    check("squash_dc", bus.dc, 32'h22);
    check("squash_pend", 32'(bus.pend_a), 32'd0);
    idle(5'd5, 5'd0);
    check("squash_pop_wec", 32'(bus.wec), 32'd0);
    idle(5'd5, 5'd0);

    // Same-cycle ALU and load to register 6 with a non-empty buffer.
    step(0, 0, 1, 5'd8, 32'h88, 1, 5'd12, 32'hC0, 5'd6, 5'd12);
    step(0, 0, 1, 5'd6, 32'h66, 1, 5'd6, 32'hBAD, 5'd6, 5'd12);
    repeat (3) idle(5'd6, 5'd12);

    // Halt with two buffered entries and a pending ALU request.
    step(0, 0, 1, 5'd15, 32'hF, 1, 5'd13, 32'h1313, 5'd13, 5'd14);
    step(0, 0, 1, 5'd16, 32'h10, 1, 5'd14, 32'h1414, 5'd13, 5'd14);
    repeat (3) step(0, 1, 1, 5'd13, 32'hBEEF, 1, 5'd20, 32'h20, 5'd13, 5'd14);
    check("halt_wec", 32'(bus.wec), 32'd0);
    repeat (3) idle(5'd13, 5'd14);

    // Reset while full drops both entries.
    step(0, 0, 1, 5'd17, 32'h17, 1, 5'd18, 32'h18, 5'd18, 5'd19);
    step(0, 0, 1, 5'd21, 32'h21, 1, 5'd19, 32'h19, 5'd18, 5'd19);
    step(1, 0, 0, '0, '0, 0, '0, '0, 5'd18, 5'd19);
    check("rst_full_wec", 32'(bus.wec), 32'd0);
    repeat (2) idle(5'd18, 5'd19);

    // Random traffic on a narrow address range to provoke collisions.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
